// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle fetch/decode/execute sequencer. It owns the PC
//               and the status register, and it drives the register-bank
//               selects and the memory handshakes.
// Revision    : 1.0  initial release
// ============================================================================
module control_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    output logic [15:0] pc,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic [3:0]  src_reg,
    output logic [3:0]  dst_reg,
    output logic [3:0]  wr_reg,
    output logic        wr_en,
    output logic [1:0]  wr_sel,
    output logic [2:0]  alu_op,
    input  logic [3:0]  alu_flags,
    input  logic [15:0] a_in,
    output logic [3:0]  status,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_LD   = 4'h8;
    localparam logic [3:0] c_OP_ST   = 4'h9;
    localparam logic [3:0] c_OP_JMP  = 4'hA;
    localparam logic [3:0] c_OP_BZ   = 4'hB;
    localparam logic [3:0] c_OP_MFSR = 4'hC;
    localparam logic [3:0] c_OP_JAL  = 4'hD;
    localparam logic [3:0] c_OP_RSVD = 4'hE;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_PC  = 2'd1;
    localparam logic [1:0] c_WB_SR  = 2'd2;
    localparam logic [1:0] c_WB_MEM = 2'd3;

    state_t      r_state;
    logic [3:0]  r_ir_op;
    logic [7:0]  r_ir_imm;
    logic        w_is_alu;
    logic [15:0] w_bz_target;

    assign w_is_alu    = ~r_ir_op[3] && (r_ir_op != c_OP_NOP);
    // pc already points past the branch, so the offset is taken from pc+1
    assign w_bz_target = pc + {{8{r_ir_imm[7]}}, r_ir_imm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ir_op   <= 4'h0;
            r_ir_imm  <= 8'h00;
            pc        <= PC_RESET;
            status    <= 4'h0;
            instr_req <= 1'b0;
            src_reg   <= 4'h0;
            dst_reg   <= 4'h0;
            wr_reg    <= 4'h0;
            alu_op    <= 3'd0;
            wr_en     <= 1'b0;
            wr_sel    <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    instr_req <= 1'b1;
                    // instr_req gates acceptance so the idle cycle after reset ignores valid
                    if (instr_req && instr_valid) begin
                        instr_req <= 1'b0;
                        r_ir_op   <= instr_data[15:12];
                        r_ir_imm  <= instr_data[7:0];
                        pc        <= pc + 16'd1;
                        src_reg   <= instr_data[7:4];
                        dst_reg   <= instr_data[3:0];
                        wr_reg    <= instr_data[11:8];
                        alu_op    <= instr_data[15] ? 3'd0 : instr_data[14:12];
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_ir_op == c_OP_NOP || r_ir_op == c_OP_RSVD) begin
                        r_state   <= S_FETCH;
                        instr_req <= 1'b1;
                    end else if (r_ir_op == c_OP_HALT) begin
                        r_state <= S_HALT;
                        halted  <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state   <= S_FETCH;
                    instr_req <= 1'b1;
                    if (w_is_alu) begin
                        status    <= alu_flags;
                        r_state   <= S_WB;
                        instr_req <= 1'b0;
                        wr_en     <= 1'b1;
                        wr_sel    <= c_WB_ALU;
                    end else begin
                        case (r_ir_op)
                            c_OP_LD, c_OP_ST: begin
                                r_state   <= S_MEM;
                                instr_req <= 1'b0;
                                mem_req   <= 1'b1;
                                mem_we    <= (r_ir_op == c_OP_ST);
                            end
                            c_OP_JMP: pc <= a_in;
                            c_OP_BZ: begin
                                if (status[3]) pc <= w_bz_target;
                            end
                            c_OP_MFSR, c_OP_JAL: begin
                                r_state   <= S_WB;
                                instr_req <= 1'b0;
                                wr_en     <= 1'b1;
                                wr_sel    <= (r_ir_op == c_OP_JAL) ? c_WB_PC : c_WB_SR;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (r_ir_op == c_OP_LD) begin
                            r_state <= S_WB;
                            wr_en   <= 1'b1;
                            wr_sel  <= c_WB_MEM;
                        end else begin
                            r_state   <= S_FETCH;
                            instr_req <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    wr_en     <= 1'b0;
                    wr_sel    <= c_WB_ALU;
                    r_state   <= S_FETCH;
                    instr_req <= 1'b1;
                    // JAL has just written the return address; now redirect
                    if (r_ir_op == c_OP_JAL) pc <= a_in;
                end
                S_HALT: ;
                default: begin
                    r_state   <= S_FETCH;
                    instr_req <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Directed bench for control_unit with an instruction-level
//               reference model and per-cycle compare.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

    localparam logic [15:0] c_PC_RESET = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req, instr_valid;
    logic [15:0] pc, instr_data, a_in;
    logic [3:0]  src_reg, dst_reg, wr_reg, alu_flags, status;
    logic        wr_en, mem_req, mem_we, mem_ack, halted;
    logic [1:0]  wr_sel;
    logic [2:0]  alu_op;

    always #5 clk = ~clk;

    control_unit #(.PC_RESET(c_PC_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .pc(pc),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .src_reg(src_reg), .dst_reg(dst_reg), .wr_reg(wr_reg),
        .wr_en(wr_en), .wr_sel(wr_sel), .alu_op(alu_op),
        .alu_flags(alu_flags), .a_in(a_in), .status(status),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .halted(halted)
    );

    int          n_vec = 0;
    int          n_fail = 0;
    int          i_wait = 0;
    int          m_wait = 0;
    bit          noise = 1'b0;
    logic [15:0] imem [logic [15:0]];
    logic [15:0] rf [16];

    function automatic logic [3:0] flagfn(input logic [3:0] a, input logic [3:0] b);
        return {a == b, a[3], b[0], a[0] ^ b[1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memories and register-bank stand-ins, updated just after each edge
    initial begin
        int icnt;
        int mcnt;
        icnt = 0; mcnt = 0;
        instr_valid = 1'b0; instr_data = 16'h0000; mem_ack = 1'b0;
        a_in = 16'h0000; alu_flags = 4'h0;
        forever begin
            @(posedge clk);
            #1;
            a_in      = rf[src_reg];
            alu_flags = flagfn(src_reg, dst_reg);
            if (instr_req) begin
                instr_valid = (icnt >= i_wait);
                instr_data  = imem.exists(pc) ? imem[pc] : 16'hF000;
                icnt++;
            end else begin
                icnt = 0;
                instr_valid = noise;
                instr_data  = 16'hF000;
            end
            if (mem_req) begin
                mem_ack = (mcnt >= m_wait);
                mcnt++;
            end else begin
                mcnt = 0;
                mem_ack = noise;
            end
        end
    end

    // Instruction-level reference model and compare process
    logic [15:0] m_pc;
    logic [3:0]  m_status;
    bit          m_halt, have_prev;
    int          cyc, exp_lat, exp_busy;
    bit          ew_v, em_v, em_we;
    logic [3:0]  ew_reg, em_rs;
    logic [1:0]  ew_sel;
    logic [15:0] ew_val;
    logic [14:0] m_fields;

    always @(negedge clk) begin : mon
        logic [15:0] d;
        logic [3:0]  op, rd, rs, rt;
        int          base;
        if (!rst_n) begin
            chk("reset_outs", {instr_req, mem_req, mem_we, wr_en, halted, src_reg, dst_reg,
                               wr_reg, wr_sel, alu_op, status}, 0);
            chk("reset_pc", pc, c_PC_RESET);
            m_pc = c_PC_RESET; m_status = 4'h0; m_halt = 1'b0; have_prev = 1'b0;
            ew_v = 1'b0; em_v = 1'b0; cyc = 0; exp_lat = 0; exp_busy = 0;
        end else begin
            cyc++;
            chk("req_exclusive", instr_req && mem_req, 0);
            chk("halted", halted, m_halt && cyc >= 2);
            if (m_halt && cyc >= 1) chk("halt_no_req", instr_req || mem_req, 0);
            if (mem_req && mem_ack) begin
                chk("mem_expected", em_v, 1);
                chk("mem_we", mem_we, em_we);
                chk("mem_addr_sel", src_reg, em_rs);
                em_v = 1'b0;
            end
            if (wr_en) begin
                chk("wr_expected", ew_v, 1);
                chk("wr_reg", wr_reg, ew_reg);
                chk("wr_sel", wr_sel, ew_sel);
                if (ew_sel == 2'd1) chk("jal_link", pc, ew_val);
                ew_v = 1'b0;
            end
            if (have_prev && cyc >= 1 && cyc <= exp_busy)
                chk("field_stable", {src_reg, dst_reg, wr_reg, alu_op}, m_fields);
            if (instr_req && instr_valid) begin
                if (have_prev) begin
                    chk("latency", cyc, exp_lat);
                    chk("pending_done", ew_v || em_v, 0);
                end
                chk("fetch_pc", pc, m_pc);
                chk("status", status, m_status);
                d = instr_data;
                op = d[15:12]; rd = d[11:8]; rs = d[7:4]; rt = d[3:0];
                m_fields = {rs, rt, rd, (op[3] ? 3'd0 : op[2:0])};
                m_pc = m_pc + 16'd1;
                base = 0;
                case (op)
                    4'h0, 4'hE: base = 2;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        base = 4; ew_v = 1'b1; ew_reg = rd; ew_sel = 2'd0;
                        m_status = flagfn(rs, rt);
                    end
                    4'h8: begin
                        base = 5; em_v = 1'b1; em_we = 1'b0; em_rs = rs;
                        ew_v = 1'b1; ew_reg = rd; ew_sel = 2'd3;
                    end
                    4'h9: begin base = 4; em_v = 1'b1; em_we = 1'b1; em_rs = rs; end
                    4'hA: begin base = 3; m_pc = rf[rs]; end
                    4'hB: begin
                        base = 3;
                        if (m_status[3]) m_pc = m_pc + {{8{d[7]}}, d[7:0]};
                    end
                    4'hC: begin base = 4; ew_v = 1'b1; ew_reg = rd; ew_sel = 2'd2; end
                    4'hD: begin
                        base = 4; ew_v = 1'b1; ew_reg = rd; ew_sel = 2'd1; ew_val = m_pc;
                        m_pc = rf[rs];
                    end
                    default: m_halt = 1'b1;
                endcase
                if (op == 4'h8 || op == 4'h9) base += m_wait;
                exp_lat   = base + i_wait;
                exp_busy  = m_halt ? 32'h4000_0000 : base - 1;
                have_prev = 1'b1;
                cyc = 0;
            end
        end
    end

    task automatic wait_fetch(input logic [15:0] a, input string nm);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (instr_req && instr_valid && pc == a) break;
        end
        chk(nm, k < 60, 1);
    endtask

    task automatic start_reset;
        @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    task automatic release_reset;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cnt, reqs;
        bit got, bad_we;
        for (int i = 0; i < 16; i++) rf[i] = 16'h1111 * i[15:0];
        rf[2] = 16'h4000; rf[11] = 16'h0010; rf[12] = 16'hFFFF;

        // Program walk: ALU, LD, MFSR, ST, ALU, JAL, JMP, BZ both ways, NOPs, HALT
        noise = 1'b1; i_wait = 0; m_wait = 3;
        imem[16'h0000] = 16'h1321; imem[16'h0001] = 16'h8540;
        imem[16'h0002] = 16'hC600; imem[16'h0003] = 16'h9034;
        imem[16'h0004] = 16'h7A98; imem[16'h0005] = 16'hD720;
        imem[16'h4000] = 16'h1155; imem[16'h4001] = 16'hA0B0;
        imem[16'h0010] = 16'hB0FE; imem[16'h000F] = 16'h1312;
        imem[16'h0011] = 16'hE123; imem[16'h0012] = 16'h0000;
        imem[16'h0013] = 16'hF000;
        release_reset();
        chk("c1_instr_req", instr_req, 1);
        chk("c1_pc", pc, 16'h0000);
        @(negedge clk);
        chk("c2_src", src_reg, 4'h2);
        chk("c2_dst", dst_reg, 4'h1);
        chk("c2_wr_reg", wr_reg, 4'h3);
        chk("c2_alu_op", alu_op, 3'd1);
        @(negedge clk);
        chk("c3_wr_en", wr_en, 0);
        @(negedge clk);
        chk("c4_wr_en", wr_en, 1);
        chk("c4_wr_reg", wr_reg, 4'h3);
        chk("c4_wr_sel", wr_sel, 2'd0);
        chk("c4_pc", pc, 16'h0001);
        @(negedge clk);
        chk("c5_status", status, 4'h2);

        cnt = 0; got = 1'b0; bad_we = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_req) cnt++;
            if (mem_req && mem_we) bad_we = 1'b1;
            if (wr_en) begin
                got = 1'b1;
                chk("ld_wr_sel", wr_sel, 2'd3);
                chk("ld_wr_reg", wr_reg, 4'h5);
                break;
            end
        end
        chk("ld_wr_seen", got, 1);
        chk("ld_mem_req_cycles", cnt, 4);
        chk("ld_mem_we", bad_we, 0);

        got = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (wr_en && wr_sel == 2'd1) begin
                got = 1'b1;
                chk("jal_wr_reg", wr_reg, 4'h7);
                chk("jal_link_pc", pc, 16'h0006);
                break;
            end
        end
        chk("jal_wr_seen", got, 1);
        wait_fetch(16'h4000, "jal_target_fetch");
        wait_fetch(16'h000F, "bz_taken_fetch");
        wait_fetch(16'h0011, "bz_not_taken_fetch");
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (halted) break;
        end
        chk("halt_seen", halted, 1);
        chk("halt_pc", pc, 16'h0014);
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            if (instr_req || mem_req) reqs++;
        end
        chk("halt_quiet", reqs, 0);

        // PC wrap with slow instruction memory
        start_reset();
        imem.delete();
        noise = 1'b0; i_wait = 2; m_wait = 0;
        imem[16'h0000] = 16'hA0C0; imem[16'hFFFF] = 16'h0000;
        release_reset();
        wait_fetch(16'hFFFF, "wrap_jmp_fetch");
        wait_fetch(16'h0000, "wrap_pc_fetch");
        repeat (10) @(negedge clk);

        // Reset asserted while a store waits for its acknowledge
        start_reset();
        imem.delete();
        noise = 1'b1; i_wait = 0; m_wait = 10;
        imem[16'h0000] = 16'h1321; imem[16'h0001] = 16'h9034;
        release_reset();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("st_mem_req", mem_req, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_status_before", status, 4'h2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {instr_req, mem_req, mem_we, wr_en, halted, status}, 0);
        chk("rst_async_pc", pc, c_PC_RESET);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("restart_instr_req", instr_req, 1);
        chk("restart_pc", pc, c_PC_RESET);
        chk("restart_status", status, 4'h0);
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
